// File: rtl/game_round_ctrl.sv
// Round sequencer for the Tom & Jerry chase game.
// Runs menu, countdown, timed play and result hold across a best-of-N match.
package game_pkg;
    localparam int TOM_W   = 32;
    localparam int TOM_H   = 48;
    localparam int JERRY_W = 24;
    localparam int JERRY_H = 24;
endpackage

module game_round_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 65_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 60,
    parameter int RESULT_SEC    = 2,
    parameter int ROUNDS        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] tom_x,
    input  logic [9:0] tom_y,
    input  logic [9:0] jerry_x,
    input  logic [9:0] jerry_y,
    output logic       move_reset,
    output logic       move_en,
    output logic [2:0] state,
    output logic [6:0] seconds_left,
    output logic [1:0] round_num,
    output logic [1:0] tom_score,
    output logic [1:0] jerry_score,
    output logic       last_winner,
    output logic       game_over
);
    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_RESULT    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX   = CW'(TICK_DIV - 1);
    localparam logic [1:0]    WIN_SCORE  = 2'(ROUNDS / 2 + 1);
    localparam logic [1:0]    LAST_ROUND = 2'(ROUNDS - 1);
    localparam logic [6:0]    CD_LOAD    = 7'(COUNTDOWN_SEC);
    localparam logic [6:0]    PLAY_LOAD  = 7'(ROUND_SEC);
    localparam logic [6:0]    RES_LOAD   = 7'(RESULT_SEC);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_tick_cnt, w_tick_cnt_nx;
    logic          r_start_d;
    logic [6:0]    r_sec, w_sec_nx;
    logic [1:0]    r_round, w_round_nx;
    logic [1:0]    r_tom, w_tom_nx;
    logic [1:0]    r_jerry, w_jerry_nx;
    logic          r_winner, w_winner_nx;
    logic          r_move_reset, r_move_en, r_game_over;
    logic          w_start_rise, w_tick, w_last_sec, w_catch;
    logic [10:0]   w_tx, w_ty, w_jx, w_jy;

    assign w_start_rise = start & ~r_start_d;
    assign w_tick       = (r_tick_cnt == TICK_MAX);
    assign w_last_sec   = w_tick && (r_sec == 7'd1);

    // Widened to 11 bits so box edges near 1023 do not wrap.
    assign w_tx = {1'b0, tom_x};
    assign w_ty = {1'b0, tom_y};
    assign w_jx = {1'b0, jerry_x};
    assign w_jy = {1'b0, jerry_y};
    assign w_catch = (w_tx < w_jx + 11'(JERRY_W)) &&
                     (w_jx < w_tx + 11'(TOM_W))   &&
                     (w_ty < w_jy + 11'(JERRY_H)) &&
                     (w_jy < w_ty + 11'(TOM_H));

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    always_comb begin
        w_state_nx  = r_state;
        w_sec_nx    = r_sec;
        w_round_nx  = r_round;
        w_tom_nx    = r_tom;
        w_jerry_nx  = r_jerry;
        w_winner_nx = r_winner;
        case (r_state)
            S_MENU, S_GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_nx = S_COUNTDOWN;
                    w_sec_nx   = CD_LOAD;
                    w_round_nx = 2'd0;
                    w_tom_nx   = 2'd0;
                    w_jerry_nx = 2'd0;
                end
            end
            S_COUNTDOWN: begin
                if (w_last_sec) begin
                    w_state_nx = S_PLAY;
                    w_sec_nx   = PLAY_LOAD;
                end else if (w_tick) begin
                    w_sec_nx = r_sec - 7'd1;
                end
            end
            S_PLAY: begin
                // Catch is checked first so a catch on the final tick goes to Tom.
                if (w_catch) begin
                    w_state_nx  = S_RESULT;
                    w_sec_nx    = RES_LOAD;
                    w_tom_nx    = sat_inc(r_tom);
                    w_winner_nx = 1'b1;
                end else if (w_last_sec) begin
                    w_state_nx  = S_RESULT;
                    w_sec_nx    = RES_LOAD;
                    w_jerry_nx  = sat_inc(r_jerry);
                    w_winner_nx = 1'b0;
                end else if (w_tick) begin
                    w_sec_nx = r_sec - 7'd1;
                end
            end
            S_RESULT: begin
                if (w_last_sec) begin
                    if (r_tom >= WIN_SCORE || r_jerry >= WIN_SCORE ||
                        r_round >= LAST_ROUND) begin
                        w_state_nx = S_GAME_OVER;
                        w_sec_nx   = 7'd0;
                    end else begin
                        w_state_nx = S_COUNTDOWN;
                        w_sec_nx   = CD_LOAD;
                        w_round_nx = r_round + 2'd1;
                    end
                end else if (w_tick) begin
                    w_sec_nx = r_sec - 7'd1;
                end
            end
            default: w_state_nx = S_MENU;
        endcase
    end

    assign w_tick_cnt_nx = (w_state_nx != r_state || w_tick) ? '0 : r_tick_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_MENU;
            r_tick_cnt   <= '0;
            r_start_d    <= 1'b0;
            r_sec        <= 7'd0;
            r_round      <= 2'd0;
            r_tom        <= 2'd0;
            r_jerry      <= 2'd0;
            r_winner     <= 1'b0;
            r_move_reset <= 1'b1;
            r_move_en    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_tick_cnt   <= w_tick_cnt_nx;
            r_start_d    <= start;
            r_sec        <= w_sec_nx;
            r_round      <= w_round_nx;
            r_tom        <= w_tom_nx;
            r_jerry      <= w_jerry_nx;
            r_winner     <= w_winner_nx;
            r_move_reset <= (w_state_nx == S_MENU) || (w_state_nx == S_COUNTDOWN);
            r_move_en    <= (w_state_nx == S_PLAY);
            r_game_over  <= (w_state_nx == S_GAME_OVER);
        end
    end

    assign state        = r_state;
    assign seconds_left = r_sec;
    assign round_num    = r_round;
    assign tom_score    = r_tom;
    assign jerry_score  = r_jerry;
    assign last_winner  = r_winner;
    assign move_reset   = r_move_reset;
    assign move_en      = r_move_en;
    assign game_over    = r_game_over;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed round scenarios, then random play,
// all checked against an elapsed-time model of the match rules.
module tb_game_round_ctrl;
    import game_pkg::*;

    localparam int TD  = 4;
    localparam int CDS = 3;
    localparam int RS  = 5;
    localparam int RES = 2;
    localparam int NR  = 3;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [9:0] tom_x, tom_y, jerry_x, jerry_y;
    logic       move_reset, move_en, last_winner, game_over;
    logic [2:0] state;
    logic [6:0] seconds_left;
    logic [1:0] round_num, tom_score, jerry_score;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase, seconds loaded on entry, cycles elapsed in the phase.
    int m_ph, m_load, m_el, m_round, m_tom, m_jerry, m_lw;
    bit m_start_d;

    game_round_ctrl #(
        .TICK_DIV(TD), .COUNTDOWN_SEC(CDS), .ROUND_SEC(RS),
        .RESULT_SEC(RES), .ROUNDS(NR)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .tom_x(tom_x), .tom_y(tom_y), .jerry_x(jerry_x), .jerry_y(jerry_y),
        .move_reset(move_reset), .move_en(move_en), .state(state),
        .seconds_left(seconds_left), .round_num(round_num),
        .tom_score(tom_score), .jerry_score(jerry_score),
        .last_winner(last_winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_sec();
        if (m_ph >= 1 && m_ph <= 3) return m_load - m_el / TD;
        return 0;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_load = 0; m_el = 0; m_round = 0;
        m_tom = 0; m_jerry = 0; m_lw = 0; m_start_d = 0;
    endtask

    task automatic m_enter(input int p, input int load);
        m_ph = p; m_load = load; m_el = 0;
    endtask

    task automatic m_step();
        bit sr, fin, ct;
        int tx, ty, jx, jy;
        if (rst) begin
            m_reset();
            return;
        end
        sr = start && !m_start_d;
        m_start_d = start;
        fin = (m_el == m_load * TD - 1);
        tx = int'(tom_x); ty = int'(tom_y);
        jx = int'(jerry_x); jy = int'(jerry_y);
        ct = (tx < jx + JERRY_W) && (jx < tx + TOM_W) &&
             (ty < jy + JERRY_H) && (jy < ty + TOM_H);
        case (m_ph)
            0, 4: begin
                if (sr) begin
                    m_enter(1, CDS);
                    m_round = 0; m_tom = 0; m_jerry = 0;
                end else m_el++;
            end
            1: if (fin) m_enter(2, RS); else m_el++;
            2: begin
                if (ct) begin
                    if (m_tom < 3) m_tom++;
                    m_lw = 1;
                    m_enter(3, RES);
                end else if (fin) begin
                    if (m_jerry < 3) m_jerry++;
                    m_lw = 0;
                    m_enter(3, RES);
                end else m_el++;
            end
            3: begin
                if (fin) begin
                    if (m_tom >= NR/2 + 1 || m_jerry >= NR/2 + 1 || m_round == NR - 1)
                        m_enter(4, 0);
                    else begin
                        m_round++;
                        m_enter(1, CDS);
                    end
                end else m_el++;
            end
            default: m_enter(0, 0);
        endcase
    endtask

    task automatic compare_all();
        check("state", state, m_ph);
        check("seconds_left", seconds_left, m_sec());
        check("round_num", round_num, m_round);
        check("tom_score", tom_score, m_tom);
        check("jerry_score", jerry_score, m_jerry);
        check("last_winner", last_winner, m_lw);
        check("game_over", game_over, m_ph == 4);
        check("move_reset", move_reset, m_ph <= 1);
        check("move_en", move_en, m_ph == 2);
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cycs(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic place_far();
        tom_x = 10'd0; tom_y = 10'd0; jerry_x = 10'd500; jerry_y = 10'd400;
    endtask

    task automatic place_catch();
        tom_x = 10'd100; tom_y = 10'd200; jerry_x = 10'd110; jerry_y = 10'd210;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        place_far();
        m_reset();
        #1;
        compare_all();
        cycs(3);
        check("rst_state", state, 0);
        check("rst_move_reset", move_reset, 1);
        rst = 1'b0;
        cycs(2);

        // Start and countdown
        start = 1'b1;
        cyc();
        check("start_state", state, 1);
        check("start_sec", seconds_left, 3);
        check("start_move_reset", move_reset, 1);
        start = 1'b0;
        cycs(12);
        check("play_state", state, 2);
        check("play_sec", seconds_left, 5);
        check("play_move_en", move_en, 1);
        check("play_move_reset", move_reset, 0);

        // Timeout: Jerry wins round 0
        cycs(20);
        check("to_state", state, 3);
        check("to_jerry", jerry_score, 1);
        check("to_winner", last_winner, 0);
        check("to_sec", seconds_left, 2);
        cycs(8);
        check("to_next_state", state, 1);
        check("to_round", round_num, 1);

        // Adjacency then catch in round 1
        cycs(12);
        tom_x = 10'd100; tom_y = 10'd200;
        jerry_x = 10'(100 + TOM_W); jerry_y = 10'd200;
        cycs(3);
        check("adj_state", state, 2);
        place_catch();
        cyc();
        check("catch_state", state, 3);
        check("catch_tom", tom_score, 1);
        check("catch_winner", last_winner, 1);
        place_far();
        cycs(8);
        check("r2_round", round_num, 2);

        // Catch on the final tick of round 2
        cycs(12);
        cycs(19);
        check("final_pre_state", state, 2);
        check("final_pre_sec", seconds_left, 1);
        place_catch();
        cyc();
        check("final_tom", tom_score, 2);
        check("final_jerry", jerry_score, 1);
        place_far();
        cycs(8);
        check("go1_state", state, 4);

        // New game from GAME_OVER, Tom takes the majority
        start = 1'b1;
        cyc();
        check("ng_state", state, 1);
        check("ng_tom", tom_score, 0);
        check("ng_jerry", jerry_score, 0);
        check("ng_round", round_num, 0);
        cycs(12);
        place_catch();
        cyc();
        place_far();
        cycs(8);
        cycs(12);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        check("ign_start_state", state, 2);
        place_catch();
        cyc();
        place_far();
        cycs(8);
        check("maj_state", state, 4);
        check("maj_game_over", game_over, 1);
        check("maj_round", round_num, 1);
        check("maj_tom", tom_score, 2);

        // Asynchronous reset mid-play
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cycs(17);
        check("pre_rst_state", state, 2);
        #3;
        rst = 1'b1;
        m_reset();
        #1;
        check("arst_state", state, 0);
        check("arst_move_en", move_en, 0);
        check("arst_move_reset", move_reset, 1);
        check("arst_tom", tom_score, 0);
        compare_all();
        cyc();
        rst = 1'b0;
        cycs(3);
        check("post_rst_state", state, 0);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) start = ~start;
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    tom_x = 10'($urandom_range(0, 1023));
                    tom_y = 10'($urandom_range(0, 1023));
                    jerry_x = 10'($urandom_range(0, 1023));
                    jerry_y = 10'($urandom_range(0, 1023));
                end else begin
                    tom_x = 10'($urandom_range(100, 900));
                    tom_y = 10'($urandom_range(100, 900));
                    jerry_x = 10'(int'(tom_x) + int'($urandom_range(0, 120)) - 60);
                    jerry_y = 10'(int'(tom_y) + int'($urandom_range(0, 120)) - 60);
                end
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TICK_DIV, 65_000_000: clk cycles per one-second tick.
- COUNTDOWN_SEC, 3: pre-round countdown length in seconds.
- ROUND_SEC, 60: round length in seconds (max 127).
- RESULT_SEC, 2: result display hold in seconds.
- ROUNDS, 3: rounds per game (1..3).
- TOM_W, TOM_H, JERRY_W, JERRY_H: from game_pkg; sprite box sizes in pixels.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  start key, level; only its rising edge is used.
- tom_x, tom_y  in  10  Tom upper-left coordinates.
- jerry_x, jerry_y  in  10  Jerry upper-left coordinates.
- move_reset  out  1  drives the reset input of both movement controllers.
- move_en  out  1  gates left/right/jump into both movement controllers.
- state  out  3  FSM state code.
- seconds_left  out  7  countdown or round seconds remaining.
- round_num  out  2  current round, 0-based.
- tom_score, jerry_score  out  2  rounds won.
- last_winner  out  1  1 = Tom won the last round, 0 = Jerry won it.
- game_over  out  1  high in GAME_OVER.

Function
REQ-003 The FSM SHALL have these states and codes: MENU=0, COUNTDOWN=1, PLAY=2, RESULT=3, GAME_OVER=4. Other codes SHALL go to MENU on the next edge.
REQ-004 All outputs SHALL be registered.
REQ-005 Start edge: start_d SHALL be a register of start. start_rise = start & ~start_d.
REQ-006 Tick counter:
- counts 0..TICK_DIV-1 with width $clog2(TICK_DIV);
- tick = (counter == TICK_DIV-1);
- counter SHALL be cleared to 0 on every state change.
REQ-007 MENU -> COUNTDOWN on start_rise.
- Same edge: seconds_left=COUNTDOWN_SEC, round_num=0, both scores=0.
REQ-008 COUNTDOWN, on tick:
- seconds_left==1: go to PLAY and load seconds_left=ROUND_SEC;
- otherwise: decrement seconds_left.
REQ-009 catch SHALL be combinational over the inputs, using 11-bit sums and strict overlap: tom_x < jerry_x+JERRY_W, jerry_x < tom_x+TOM_W, tom_y < jerry_y+JERRY_H, jerry_y < tom_y+TOM_H.
REQ-010 PLAY:
- catch: go to RESULT, tom_score+1, last_winner=1;
- else tick with seconds_left==1: go to RESULT, jerry_score+1, last_winner=0;
- else tick: decrement seconds_left.
- RESULT entry SHALL load seconds_left=RESULT_SEC.
REQ-011 If catch and the final tick occur in the same cycle, catch SHALL win (Tom).
REQ-012 RESULT, on tick with seconds_left==1:
- if either score >= ROUNDS/2+1, or round_num==ROUNDS-1: go to GAME_OVER;
- otherwise: round_num+1, go to COUNTDOWN, seconds_left=COUNTDOWN_SEC.
- Other ticks SHALL decrement seconds_left.
REQ-013 GAME_OVER: game_over=1, seconds_left=0, scores held.
- start_rise SHALL act exactly as REQ-007.
REQ-014 start_rise SHALL be ignored in COUNTDOWN, PLAY and RESULT.
REQ-015 Gating outputs:
- move_reset=1 in MENU and COUNTDOWN, else 0;
- move_en=1 only in PLAY.
- Both SHALL reflect the state in the same cycle as state.
REQ-016 Scores SHALL saturate at 3; round_num SHALL never exceed ROUNDS-1.

Reset
REQ-017 While rst is high, outputs SHALL immediately take these values: state=MENU, move_reset=1, move_en=0, seconds_left=0, round_num=0, scores=0, last_winner=0, game_over=0, tick counter=0, start_d=0.
REQ-018 rst asserted in any state, including mid-PLAY, SHALL abort the game with no score update. The first operation after rst release SHALL be MENU.

Verification
Bench parameters: TICK_DIV=4, COUNTDOWN_SEC=3, ROUND_SEC=5, RESULT_SEC=2, ROUNDS=3.
REQ-019 Bench SHALL cover these directed scenarios:
- Start: start 0->1 -> COUNTDOWN, seconds_left=3, move_reset=1. 12 cycles later -> PLAY, seconds_left=5, move_en=1, move_reset=0.
- Timeout: PLAY with no overlap for 20 cycles -> RESULT, jerry_score=1, last_winner=0, seconds_left=2. 8 cycles later -> COUNTDOWN, round_num=1.
- Catch: tom=(100,200), jerry=(110,210) in PLAY -> RESULT next edge, tom_score=1. Catch on the final tick cycle -> tom_score increments, jerry_score unchanged.
- Adjacency: tom_x+TOM_W == jerry_x with equal y -> no catch, stays in PLAY.
- Majority: Tom wins rounds 0 and 1 -> GAME_OVER after second RESULT, game_over=1, round_num=1. Start 0->1 -> COUNTDOWN, scores=0, round_num=0. Start held high in PLAY causes no effect.
- Async reset: rst pulsed mid-PLAY between edges -> state=MENU, move_en=0, move_reset=1, scores=0 before the next edge.
